// File: rtl/bus_rr_arbiter.sv
// Four-requester round-robin bus arbiter with a registered output stage.
// Define BUS_ARB_LOCK_EN to hold the grant for a whole packet (until last_i).
module bus_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       valid_i,
    input  logic [NREQ*WIDTH-1:0] data_i,
    input  logic [NREQ-1:0]       last_i,
    output logic [NREQ-1:0]       ready_o,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  last_o,
    output logic [1:0]            id_o,
    input  logic                  ready_i
);

    // state  | meaning
    // IDLE   | arbitrate every cycle from ptr upward
    // LOCKED | grant held by owner until its last beat
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state, state_next;
    logic [1:0] ptr;
    logic [1:0] owner, owner_next;
    logic [1:0] grant;
    logic [1:0] idx;
    logic       gnt_valid;
    logic       load;
    logic       xfer;

    assign load = ~valid_o | ready_i;
    assign xfer = load & gnt_valid & ~rst;

    // Descending scan so the requester closest to ptr is the last (winning) hit.
    always_comb begin
        grant     = ptr;
        gnt_valid = 1'b0;
        idx       = ptr;
        if (state == LOCKED) begin
            grant     = owner;
            gnt_valid = valid_i[owner];
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                idx = ptr + 2'(i);
                if (valid_i[idx]) begin
                    grant     = idx;
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (xfer)
            ready_o[grant] = 1'b1;
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
`ifdef BUS_ARB_LOCK_EN
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (!last_i[grant]) begin
                        state_next = LOCKED;
                        owner_next = grant;
                    end
                end
                LOCKED: begin
                    if (last_i[grant])
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 2'd0;
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            id_o    <= 2'd0;
        end else if (xfer) begin
            ptr     <= grant + 2'd1;
            valid_o <= 1'b1;
            data_o  <= data_i[int'(grant)*WIDTH +: WIDTH];
            last_o  <= last_i[grant];
            id_o    <= grant;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter; compile with +define+BUS_ARB_LOCK_EN to
// exercise the packet-lock scenarios instead of the interleaving ones.
module tb_bus_rr_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     valid_i;
    logic [4*W-1:0] data_i;
    logic [3:0]     last_i;
    logic [3:0]     ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic           last_o;
    logic [1:0]     id_o;
    logic           ready_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    bus_rr_arbiter #(.WIDTH(W), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
        .id_o(id_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        valid_i = 4'b0000;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        step();
        step();
        total_cnt++; if (ready_o !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", ready_o); else pass_cnt++;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else pass_cnt++;
        total_cnt++; if (data_o !== '0) $display("FAIL reset_data: got %h expected 0", data_o); else pass_cnt++;
        total_cnt++; if (last_o !== 1'b0) $display("FAIL reset_last: got %b expected 0", last_o); else pass_cnt++;
        total_cnt++; if (id_o !== 2'd0) $display("FAIL reset_id: got %0d expected 0", id_o); else pass_cnt++;
        rst     = 1'b0;
        valid_i = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        apply_reset();
        for (int k = 0; k < 4; k++) data_i[k*W +: W] = 32'h1000_0000 + k;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_id = 2'(i % 4);
            #1;
            total_cnt++; if (ready_o !== (4'b0001 << exp_id)) $display("FAIL rr_ready[%0d]: got %b expected %b", i, ready_o, 4'b0001 << exp_id); else pass_cnt++;
            step();
            total_cnt++; if (id_o !== exp_id) $display("FAIL rr_id[%0d]: got %0d expected %0d", i, id_o, exp_id); else pass_cnt++;
            total_cnt++; if (valid_o !== 1'b1) $display("FAIL rr_valid[%0d]: got %b expected 1", i, valid_o); else pass_cnt++;
            total_cnt++; if (data_o !== 32'h1000_0000 + 32'(exp_id)) $display("FAIL rr_data[%0d]: got %h expected %h", i, data_o, 32'h1000_0000 + 32'(exp_id)); else pass_cnt++;
        end
        valid_i = 4'b0000;
        step();
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL rr_drain: got %b expected 0", valid_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        data_i[2*W +: W] = 32'hAAAA_0002;
        valid_i = 4'b0100;
        last_i  = 4'b1111;
        ready_i = 1'b0;
        #1;
        total_cnt++; if (ready_o !== 4'b0100) $display("FAIL bp_ready_first: got %b expected 0100", ready_o); else pass_cnt++;
        step();
        total_cnt++; if (valid_o !== 1'b1 || id_o !== 2'd2 || data_o !== 32'hAAAA_0002) $display("FAIL bp_load: got v=%b id=%0d d=%h expected v=1 id=2 d=aaaa0002", valid_o, id_o, data_o); else pass_cnt++;
        data_i[2*W +: W] = 32'hBBBB_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (ready_o !== 4'b0000) $display("FAIL bp_ready_hold[%0d]: got %b expected 0000", i, ready_o); else pass_cnt++;
            step();
            total_cnt++; if (valid_o !== 1'b1 || id_o !== 2'd2 || data_o !== 32'hAAAA_0002) $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=2 d=aaaa0002", i, valid_o, id_o, data_o); else pass_cnt++;
        end
        ready_i = 1'b1;
        #1;
        total_cnt++; if (ready_o !== 4'b0100) $display("FAIL bp_ready_release: got %b expected 0100", ready_o); else pass_cnt++;
        step();
        total_cnt++; if (valid_o !== 1'b1 || data_o !== 32'hBBBB_0002) $display("FAIL bp_next: got v=%b d=%h expected v=1 d=bbbb0002", valid_o, data_o); else pass_cnt++;
        valid_i = 4'b0000;
        step();
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL bp_drain: got %b expected 0", valid_o); else pass_cnt++;
    endtask

    task automatic test_two_requesters();
        logic [3:0] tv [6];
        logic       tl1 [6];
        logic [1:0] tid [6];
        logic       tlo [6];
        int n;
`ifdef BUS_ARB_LOCK_EN
        n = 4;
        tv  = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        tl1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tid = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        tlo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        n = 6;
        tv  = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
        tl1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tid = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        tlo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        apply_reset();
        valid_i = 4'b0001;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            valid_i = tv[i];
            last_i  = {2'b11, tl1[i], 1'b1};
            step();
            total_cnt++; if (id_o !== tid[i] || valid_o !== 1'b1) $display("FAIL pkt_id[%0d]: got id=%0d v=%b expected id=%0d v=1", i, id_o, valid_o, tid[i]); else pass_cnt++;
            total_cnt++; if (last_o !== tlo[i]) $display("FAIL pkt_last[%0d]: got %b expected %b", i, last_o, tlo[i]); else pass_cnt++;
        end
        valid_i = 4'b0000;
        last_i  = 4'b1111;
        step();
    endtask

`ifdef BUS_ARB_LOCK_EN
    task automatic test_owner_stall();
        apply_reset();
        ready_i = 1'b1;
        valid_i = 4'b0100;
        last_i  = 4'b1011;
        step();
        total_cnt++; if (id_o !== 2'd2 || valid_o !== 1'b1) $display("FAIL stall_first: got id=%0d v=%b expected id=2 v=1", id_o, valid_o); else pass_cnt++;
        valid_i = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++; if (ready_o !== 4'b0000) $display("FAIL stall_ready[%0d]: got %b expected 0000", i, ready_o); else pass_cnt++;
            step();
            total_cnt++; if (valid_o !== 1'b0) $display("FAIL stall_valid[%0d]: got %b expected 0", i, valid_o); else pass_cnt++;
        end
        valid_i = 4'b0111;
        last_i  = 4'b1111;
        #1;
        total_cnt++; if (ready_o !== 4'b0100) $display("FAIL stall_resume_ready: got %b expected 0100", ready_o); else pass_cnt++;
        step();
        total_cnt++; if (id_o !== 2'd2 || last_o !== 1'b1) $display("FAIL stall_resume: got id=%0d last=%b expected id=2 last=1", id_o, last_o); else pass_cnt++;
        valid_i = 4'b0011;
        step();
        total_cnt++; if (id_o !== 2'd0) $display("FAIL stall_unlock: got id=%0d expected 0", id_o); else pass_cnt++;
        valid_i = 4'b0000;
        step();
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 4; k++) data_i[k*W +: W] = 32'hC000_0000 + k;
        valid_i = 4'b0100;
        last_i  = 4'b1011;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        step();
        total_cnt++; if (valid_o !== 1'b1 || id_o !== 2'd2) $display("FAIL mid_pre: got v=%b id=%0d expected v=1 id=2", valid_o, id_o); else pass_cnt++;
        rst     = 1'b1;
        valid_i = 4'b1111;
        #1;
        total_cnt++; if (ready_o !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", ready_o); else pass_cnt++;
        step();
        total_cnt++; if (valid_o !== 1'b0 || id_o !== 2'd0 || data_o !== '0 || last_o !== 1'b0) $display("FAIL mid_rst_out: got v=%b id=%0d d=%h l=%b expected all 0", valid_o, id_o, data_o, last_o); else pass_cnt++;
        rst     = 1'b0;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        #1;
        total_cnt++; if (ready_o !== 4'b0001) $display("FAIL mid_first_ready: got %b expected 0001", ready_o); else pass_cnt++;
        step();
        total_cnt++; if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 32'hC000_0000) $display("FAIL mid_first_beat: got v=%b id=%0d d=%h expected v=1 id=0 d=c0000000", valid_o, id_o, data_o); else pass_cnt++;
        valid_i = 4'b0000;
        step();
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 4'b0000;
        data_i  = '0;
        last_i  = 4'b1111;
        ready_i = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_two_requesters();
`ifdef BUS_ARB_LOCK_EN
        test_owner_stall();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
